// File: rtl/clock_pkg.sv
// Shared definitions for the time-set controller.
// Holds field limits, the controller state encoding, the field_sel codes
// and the saturating-free wrap helpers used by the edit datapath.
package clock_pkg;

  localparam logic [7:0] HR_MAX  = 8'd23;
  localparam logic [7:0] MIN_MAX = 8'd59;
  localparam logic [7:0] SEC_MAX = 8'd59;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_SET_SEC = 3'd3,
    ST_LOAD    = 3'd4
  } state_e;

  localparam logic [1:0] FS_NONE = 2'b00;
  localparam logic [1:0] FS_HR   = 2'b01;
  localparam logic [1:0] FS_MIN  = 2'b10;
  localparam logic [1:0] FS_SEC  = 2'b11;

  // Live counter values outside the legal range are replaced by 0.
  function automatic logic [7:0] clamp_capture(input logic [7:0] val,
                                               input logic [7:0] max_val);
    clamp_capture = (val > max_val) ? 8'd0 : val;
  endfunction

  // One up/down step with wrap; compares against the limit before
  // stepping so 8-bit overflow is never relied on. Both or neither
  // direction leaves the value unchanged.
  function automatic logic [7:0] step_field(input logic [7:0] val,
                                            input logic [7:0] max_val,
                                            input logic       inc,
                                            input logic       dec);
    step_field = val;
    if (inc && !dec) begin
      step_field = (val >= max_val) ? 8'd0 : val + 8'd1;
    end else if (dec && !inc) begin
      step_field = (val == 8'd0 || val > max_val) ? max_val : val - 8'd1;
    end
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge pulse generator for one synchronised, debounced button level.
// Ports:
//   clk_i    in  1  system clock
//   rst_ni   in  1  asynchronous active-low reset
//   btn_i    in  1  button level
//   pulse_o  out 1  registered one-cycle pulse, high the cycle after a 0->1 step
module btn_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);

  logic btn_q;
  logic pulse_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      btn_q   <= btn_i;
      pulse_q <= btn_i & ~btn_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller for the 24 h HH:MM:SS counter.
// A mode press opens an edit session (hours -> minutes -> seconds -> load),
// up/down presses step the selected field with wrap, and the final mode
// press holds load high long enough for the counter's 1 Hz domain to see it.
// An edit left idle for TIMEOUT_CYCLES is abandoned without loading.
// Ports:
//   CLK100MHZ                       in  1  system clock
//   reset_n                         in  1  asynchronous active-low reset
//   btn_mode/btn_up/btn_down        in  1  debounced button levels
//   hours/minutes/seconds           in  8  live counter value
//   newHours/newMinutes/newSeconds  out 8  edit registers to the counter
//   load                            out 1  counter load strobe
//   editing                         out 1  high in any SET_* state
//   field_sel                       out 2  selected field code
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned LOAD_HOLD_CYCLES = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES   = 1_000_000_000
) (
  input  logic       CLK100MHZ,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [7:0] hours,
  input  logic [7:0] minutes,
  input  logic [7:0] seconds,
  output logic [7:0] newHours,
  output logic [7:0] newMinutes,
  output logic [7:0] newSeconds,
  output logic       load,
  output logic       editing,
  output logic [1:0] field_sel
);

  localparam int unsigned HOLD_W = (LOAD_HOLD_CYCLES > 1) ? $clog2(LOAD_HOLD_CYCLES) : 1;
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOAD_HOLD_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  // Button order in the vector: 0 = mode, 1 = up, 2 = down.
  logic [2:0] btn_lvl;
  logic [2:0] btn_pulse;
  logic       mode_p, up_p, dn_p;

  assign btn_lvl = {btn_down, btn_up, btn_mode};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
      btn_edge u_edge (
        .clk_i  (CLK100MHZ),
        .rst_ni (reset_n),
        .btn_i  (btn_lvl[gi]),
        .pulse_o(btn_pulse[gi])
      );
    end
  endgenerate

  assign mode_p = btn_pulse[0];
  assign up_p   = btn_pulse[1];
  assign dn_p   = btn_pulse[2];

  state_e            state_q, state_d;
  logic [7:0]        hr_q, hr_d, min_q, min_d, sec_q, sec_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              load_q, load_d;
  logic              editing_q, editing_d;
  logic [1:0]        field_q, field_d;

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_RUN;
      hr_q      <= 8'd0;
      min_q     <= 8'd0;
      sec_q     <= 8'd0;
      idle_q    <= '0;
      hold_q    <= '0;
      load_q    <= 1'b0;
      editing_q <= 1'b0;
      field_q   <= FS_NONE;
    end else begin
      state_q   <= state_d;
      hr_q      <= hr_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      idle_q    <= idle_d;
      hold_q    <= hold_d;
      load_q    <= load_d;
      editing_q <= editing_d;
      field_q   <= field_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hr_d    = hr_q;
    min_d   = min_q;
    sec_d   = sec_q;
    idle_d  = idle_q;
    hold_d  = hold_q;

    case (state_q)
      ST_RUN: begin
        if (mode_p) begin
          hr_d    = clamp_capture(hours, HR_MAX);
          min_d   = clamp_capture(minutes, MIN_MAX);
          sec_d   = clamp_capture(seconds, SEC_MAX);
          idle_d  = '0;
          state_d = ST_SET_HR;
        end
      end
      ST_SET_HR, ST_SET_MIN, ST_SET_SEC: begin
        // mode outranks up/down; any pulse restarts the idle count,
        // so the timeout only fires on a pulse-free cycle.
        if (mode_p) begin
          idle_d = '0;
          case (state_q)
            ST_SET_HR:  state_d = ST_SET_MIN;
            ST_SET_MIN: state_d = ST_SET_SEC;
            default: begin
              state_d = ST_LOAD;
              hold_d  = '0;
            end
          endcase
        end else if (up_p || dn_p) begin
          idle_d = '0;
          case (state_q)
            ST_SET_HR:  hr_d  = step_field(hr_q, HR_MAX, up_p, dn_p);
            ST_SET_MIN: min_d = step_field(min_q, MIN_MAX, up_p, dn_p);
            default:    sec_d = step_field(sec_q, SEC_MAX, up_p, dn_p);
          endcase
        end else if (idle_q == IDLE_LAST) begin
          state_d = ST_RUN;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      ST_LOAD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Flag outputs are derived from the next state so they register
    // on the same edge as the state itself.
    load_d    = (state_d == ST_LOAD);
    editing_d = (state_d == ST_SET_HR) || (state_d == ST_SET_MIN) || (state_d == ST_SET_SEC);
    case (state_d)
      ST_SET_HR:  field_d = FS_HR;
      ST_SET_MIN: field_d = FS_MIN;
      ST_SET_SEC: field_d = FS_SEC;
      default:    field_d = FS_NONE;
    endcase
  end

  assign newHours   = hr_q;
  assign newMinutes = min_q;
  assign newSeconds = sec_q;
  assign load       = load_q;
  assign editing    = editing_q;
  assign field_sel  = field_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

  localparam int LH = 4;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [7:0] hours = 8'd0, minutes = 8'd0, seconds = 8'd0;
  logic [7:0] newHours, newMinutes, newSeconds;
  logic       load, editing;
  logic [1:0] field_sel;

  clock_set_ctrl #(
    .LOAD_HOLD_CYCLES(LH),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .CLK100MHZ (clk),
    .reset_n   (reset_n),
    .btn_mode  (btn_mode),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .hours     (hours),
    .minutes   (minutes),
    .seconds   (seconds),
    .newHours  (newHours),
    .newMinutes(newMinutes),
    .newSeconds(newSeconds),
    .load      (load),
    .editing   (editing),
    .field_sel (field_sel)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: md 0=running, 1=hours, 2=minutes, 3=seconds, 4=loading.
  int md = 0;
  int mh = 0, mm = 0, ms = 0;

  typedef struct {
    string    nm;
    bit       ed;
    bit [1:0] fs;
    bit [7:0] h, m, s;
    bit       ld;
  } exp_t;

  typedef struct {
    int       len;
    bit [7:0] h, m, s;
  } lexp_t;

  exp_t  exp_q[$];
  lexp_t lexp_q[$];
  event  exp_ev;

  task automatic push_exp(input string nm);
    exp_t e;
    e.nm = nm;
    e.ed = (md >= 1 && md <= 3);
    e.fs = e.ed ? 2'(md) : 2'd0;
    e.h  = 8'(mh);
    e.m  = 8'(mm);
    e.s  = 8'(ms);
    e.ld = (md == 4);
    exp_q.push_back(e);
    ->exp_ev;
  endtask

  // Output monitor: compares the DUT outputs whenever an expectation is queued.
  initial begin
    exp_t e;
    forever begin
      @(exp_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({editing, field_sel, newHours, newMinutes, newSeconds, load} !==
            {e.ed, e.fs, e.h, e.m, e.s, e.ld}) begin
          bad++;
          $display("FAIL %s: got ed=%0d fs=%0d t=%0d:%0d:%0d ld=%0d want ed=%0d fs=%0d t=%0d:%0d:%0d ld=%0d",
                   e.nm, editing, field_sel, newHours, newMinutes, newSeconds, load,
                   e.ed, e.fs, e.h, e.m, e.s, e.ld);
        end else begin
          $display("txn %s: ed=%0d fs=%0d t=%0d:%0d:%0d ld=%0d ok",
                   e.nm, editing, field_sel, newHours, newMinutes, newSeconds, load);
        end
      end
    end
  end

  // Load monitor: measures each load pulse and checks new* against the model.
  initial begin
    int    run;
    bit    ok;
    bit    have;
    lexp_t c;
    run = 0; ok = 1'b1; have = 1'b0;
    c = '{len: 0, h: 8'd0, m: 8'd0, s: 8'd0};
    forever begin
      @(negedge clk);
      if (load === 1'b1) begin
        if (run == 0) begin
          ok = 1'b1;
          if (lexp_q.size() == 0) begin
            total++;
            bad++;
            have = 1'b0;
            $display("FAIL unexpected_load: got load=1 want load=0");
          end else begin
            c    = lexp_q.pop_front();
            have = 1'b1;
          end
        end
        run++;
        if (have && {newHours, newMinutes, newSeconds} !== {c.h, c.m, c.s}) ok = 1'b0;
      end else if (run > 0) begin
        if (have) begin
          total++;
          if (run != c.len || !ok) begin
            bad++;
            $display("FAIL load_pulse: got len=%0d stable=%0d want len=%0d stable=1 t=%0d:%0d:%0d",
                     run, ok, c.len, c.h, c.m, c.s);
          end else begin
            $display("txn load_pulse: len=%0d t=%0d:%0d:%0d ok", run, c.h, c.m, c.s);
          end
        end
        run  = 0;
        have = 1'b0;
      end
    end
  end

  // One button transaction; must be called at a negedge. Updates the model,
  // drives the press for two cycles, releases for one, then queues a check.
  task automatic apply(input bit bm, input bit bu, input bit bd,
                       input string nm, input bit full_load);
    lexp_t l;
    if (bm) begin
      case (md)
        0: begin
          mh = (hours > 8'd23) ? 0 : int'(hours);
          mm = (minutes > 8'd59) ? 0 : int'(minutes);
          ms = (seconds > 8'd59) ? 0 : int'(seconds);
          md = 1;
        end
        1, 2: md = md + 1;
        3: begin
          md    = 4;
          l.len = full_load ? LH : 2;
          l.h   = 8'(mh);
          l.m   = 8'(mm);
          l.s   = 8'(ms);
          lexp_q.push_back(l);
        end
        default: ;
      endcase
    end else if (md >= 1 && md <= 3 && bu != bd) begin
      if (md == 1)      mh = bu ? (mh + 1) % 24 : (mh + 23) % 24;
      else if (md == 2) mm = bu ? (mm + 1) % 60 : (mm + 59) % 60;
      else              ms = bu ? (ms + 1) % 60 : (ms + 59) % 60;
    end
    btn_mode = bm; btn_up = bu; btn_down = bd;
    @(negedge clk);
    @(negedge clk);
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    @(negedge clk);
    push_exp(nm);
    if (md == 4 && full_load) begin
      repeat (8) @(negedge clk);
      md = 0;
      push_exp({nm, "_after"});
    end
  endtask

  // Asserts reset now, checks outputs before any clock edge, releases at next negedge.
  task automatic reset_now(input string nm);
    reset_n = 1'b0;
    md = 0; mh = 0; mm = 0; ms = 0;
    #1;
    push_exp(nm);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    repeat (3) @(negedge clk);
    push_exp("reset_state");
    reset_n = 1'b1;
    @(negedge clk);
    push_exp("after_release");

    // Capture, hours wrap upward.
    hours = 8'd12; minutes = 8'd34; seconds = 8'd56;
    apply(1, 0, 0, "enter_hr", 1);
    for (int i = 0; i < 12; i++) apply(0, 1, 0, $sformatf("hr_up%0d", i), 1);
    apply(1, 0, 0, "to_min", 1);
    for (int i = 0; i < 26; i++) apply(0, 1, 0, $sformatf("min_up%0d", i), 1);
    apply(0, 0, 1, "min_wrap_down", 1);
    apply(1, 0, 0, "to_sec", 1);
    for (int i = 0; i < 3; i++) apply(0, 1, 0, $sformatf("sec_up%0d", i), 1);
    apply(0, 1, 0, "sec_wrap_up", 1);
    apply(0, 1, 1, "up_down_same", 1);
    apply(1, 1, 0, "mode_beats_up", 1);

    // Reset in the middle of an edit.
    hours = 8'd7; minutes = 8'd8; seconds = 8'd9;
    apply(1, 0, 0, "edit2_enter", 1);
    apply(0, 0, 1, "edit2_down", 1);
    @(posedge clk);
    #2;
    reset_now("reset_mid_edit");

    // Timeout, restarted by an up press part-way through.
    hours = 8'd5; minutes = 8'd6; seconds = 8'd7;
    apply(1, 0, 0, "to_enter", 1);
    repeat (8) @(negedge clk);
    apply(0, 1, 0, "to_restart", 1);
    repeat (14) @(negedge clk);
    push_exp("to_still_editing");
    @(negedge clk);
    md = 0;
    push_exp("to_expired");
    repeat (10) @(negedge clk);
    push_exp("to_no_load");

    // Out-of-range capture, then reset in the 2nd LOAD cycle.
    hours = 8'd30; minutes = 8'd70; seconds = 8'd59;
    apply(1, 0, 0, "capture_range", 1);
    apply(1, 0, 0, "cut_min", 1);
    apply(1, 0, 1, "cut_sec_mode_beats_down", 1);
    apply(1, 0, 0, "load_cut", 0);
    #1;
    reset_now("reset_mid_load");

    // Randomised sessions.
    for (int t = 0; t < 70; t++) begin
      if (md == 0) begin
        hours   = 8'($urandom_range(0, 27));
        minutes = 8'($urandom_range(0, 63));
        seconds = 8'($urandom_range(0, 63));
      end
      r = int'($urandom_range(0, 9));
      apply(r <= 2 || r >= 8,
            r == 3 || r == 4 || r == 7 || r == 8,
            r == 5 || r == 6 || r == 7 || r == 9,
            $sformatf("rnd%0d_op%0d", t, r), 1);
      if (t == 35) begin
        @(posedge clk);
        #2;
        reset_now("reset_rnd");
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    total++;
    if (lexp_q.size() != 0) begin
      bad++;
      $display("FAIL load_count: got %0d pending load pulses want 0", lexp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
